// File: rtl/xbtn_sw_input_pkg.sv
// Shared constants for the button/switch input peripheral: read-word layout,
// clear-control bits and default debounce sizing.
package xbtn_sw_input_pkg;

   localparam int XBTN_SW_DEBOUNCE_DEF = 500000;
   localparam int XBTN_SW_CNT_W_DEF    = 19;
   localparam int XBTN_SW_DATA_W_DEF   = 32;

   localparam int XBTN_SW_SW_W         = 8;
   localparam int XBTN_SW_PCNT_W       = 8;
   localparam int XBTN_SW_LEVEL_BIT    = 8;
   localparam int XBTN_SW_FLAG_BIT     = 9;
   localparam int XBTN_SW_CNT_LSB      = 10;

   // Write-data bits that clear the event flag and the press counter.
   localparam int XBTN_SW_CLR_FLAG_BIT = 0;
   localparam int XBTN_SW_CLR_CNT_BIT  = 1;

   typedef struct packed {
      logic [XBTN_SW_PCNT_W-1:0] press_cnt;
      logic                      flag;
      logic                      level;
      logic [XBTN_SW_SW_W-1:0]   sw;
   } rd_word_t;

   localparam int XBTN_SW_WORD_W = $bits(rd_word_t);

endpackage

// File: rtl/xdebounce_bit.sv
// One-bit two-flop synchronizer followed by a consecutive-disagreement
// counter; the stable level flips only after DEBOUNCE_CYCLES agreeing samples.
module xdebounce_bit
   import xbtn_sw_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = XBTN_SW_DEBOUNCE_DEF,
   parameter int CNT_W           = XBTN_SW_CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic stable
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Any sample matching the stable level restarts qualification from zero.
   always_comb begin
      sync1_d  = raw;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable = stable_q;

endmodule

// File: rtl/xbtn_sw_input.sv
// Button/switch input peripheral: debounced Btn3, conditioned Sw[7:0], sticky
// press flag and press counter, read as one bus word. Define XBTN_SW_DEBOUNCE_EN
// to debounce the switches too (otherwise they are only synchronized).
module xbtn_sw_input
   import xbtn_sw_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = XBTN_SW_DEBOUNCE_DEF,
   parameter int CNT_W           = XBTN_SW_CNT_W_DEF,
   parameter int DATA_W          = XBTN_SW_DATA_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    btn_raw,
   input  logic [XBTN_SW_SW_W-1:0] sw_raw,
   input  logic                    sel,
   input  logic                    we,
   input  logic [DATA_W-1:0]       data_in,
   output logic [DATA_W-1:0]       data_out,
   output logic                    btn_level,
   output logic                    btn_press
);

   logic                      btn_stable;
   logic [XBTN_SW_SW_W-1:0]   sw_stable;
   logic                      btn_prev_q, btn_prev_d;
   logic                      flag_q, flag_d;
   logic [XBTN_SW_PCNT_W-1:0] pcnt_q, pcnt_d;
   logic                      rd_acc, wr_acc, clr_flag, clr_cnt;
   rd_word_t                  rd_word;
   logic                      unused_data_in;

   xdebounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_btn_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw),
      .stable(btn_stable)
   );

`ifdef XBTN_SW_DEBOUNCE_EN
   for (genvar i = 0; i < XBTN_SW_SW_W; i++) begin : g_sw_db
      xdebounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_sw_db (
         .clk   (clk),
         .rst   (rst),
         .raw   (sw_raw[i]),
         .stable(sw_stable[i])
      );
   end
`else
   logic [XBTN_SW_SW_W-1:0] sw_sync1_q, sw_sync1_d;
   logic [XBTN_SW_SW_W-1:0] sw_sync2_q, sw_sync2_d;

   always_comb begin
      sw_sync1_d = sw_raw;
      sw_sync2_d = sw_sync1_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_sync1_q <= '0;
         sw_sync2_q <= '0;
      end else begin
         sw_sync1_q <= sw_sync1_d;
         sw_sync2_q <= sw_sync2_d;
      end
   end

   assign sw_stable = sw_sync2_q;
`endif

   assign rd_acc    = sel & ~we;
   assign wr_acc    = sel & we;
   assign clr_flag  = rd_acc | (wr_acc & data_in[XBTN_SW_CLR_FLAG_BIT]);
   assign clr_cnt   = wr_acc & data_in[XBTN_SW_CLR_CNT_BIT];
   assign btn_press = btn_stable & ~btn_prev_q;
   assign btn_level = btn_stable;

   assign unused_data_in = ^data_in[DATA_W-1:XBTN_SW_CLR_CNT_BIT+1];

   // A press landing on the same edge as a clear wins in both the flag and the count.
   always_comb begin
      btn_prev_d = btn_stable;
      flag_d     = flag_q;
      pcnt_d     = pcnt_q;
      if (btn_press) begin
         flag_d = 1'b1;
      end else if (clr_flag) begin
         flag_d = 1'b0;
      end
      if (clr_cnt) begin
         pcnt_d = {{(XBTN_SW_PCNT_W-1){1'b0}}, btn_press};
      end else if (btn_press) begin
         pcnt_d = pcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_prev_q <= 1'b0;
         flag_q     <= 1'b0;
         pcnt_q     <= '0;
      end else begin
         btn_prev_q <= btn_prev_d;
         flag_q     <= flag_d;
         pcnt_q     <= pcnt_d;
      end
   end

   always_comb begin
      rd_word           = '0;
      rd_word.press_cnt = pcnt_q;
      rd_word.flag      = flag_q;
      rd_word.level     = btn_stable;
      rd_word.sw        = sw_stable;
      data_out          = '0;
      if (sel) begin
         data_out[XBTN_SW_WORD_W-1:0] = rd_word;
      end
   end

endmodule
